// File: rtl/sprite_bank_mem_if.sv
// Loader-side write port of the sprite bank memory: a valid/ready pixel stream
// with an end-of-image marker.
interface sprite_bank_mem_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;

  modport master (output wr_valid, output wr_addr, output wr_data, output wr_last,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data, input  wr_last,
                  output wr_ready);
endinterface

// File: rtl/sprite_bank_mem.sv
// Double-buffered 64x64 sprite memory: the drawer reads the front bank, the loader
// fills the back bank, and the banks trade places on a vsync rising edge.
module sprite_bank_mem #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pixel_addr,
  output logic [DATA_W-1:0] rgb_pixel,
  input  logic              vsync_in,
  sprite_bank_mem_if.slave  wr,
  output logic              front_bank,
  output logic              swap_pending,
  output logic [ADDR_W:0]   wr_count,
  output logic [CNT_W-1:0]  swap_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = DEPTH[ADDR_W:0];

  typedef enum logic {LOAD, WAIT_SWAP} state_t;

  state_t            state_q, state_d;
  logic              front_q, front_d;
  logic              pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]  swap_q, swap_d;
  logic              vsync_q;
  logic [DATA_W-1:0] rgb_q;
  logic              wr_en;
  logic              vs_rise;

  // Both banks live in one array; the top address bit selects the bank.
  logic [DATA_W-1:0] mem [2*DEPTH];

  assign vs_rise     = vsync_in & ~vsync_q;
  assign wr.wr_ready = (state_q == LOAD);
  assign wr_en       = wr.wr_valid & wr.wr_ready;

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    swap_d  = swap_q;
    case (state_q)
      LOAD: begin
        if (wr_en) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + (ADDR_W+1)'(1);
          if (wr.wr_last) begin
            state_d = WAIT_SWAP;
            pend_d  = 1'b1;
          end
        end
      end
      WAIT_SWAP: begin
        if (vs_rise) begin
          state_d = LOAD;
          front_d = ~front_q;
          swap_d  = swap_q + CNT_W'(1);
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      swap_q  <= '0;
      vsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      swap_q  <= swap_d;
      vsync_q <= vsync_in;
    end
  end

  // Writes only ever touch the back bank, so they never collide with reads.
  always_ff @(posedge pclk) begin
    if (wr_en) mem[{~front_q, wr.wr_addr}] <= wr.wr_data;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= mem[{front_q, pixel_addr}];
  end

  assign rgb_pixel    = rgb_q;
  assign front_bank   = front_q;
  assign swap_pending = pend_q;
  assign wr_count     = cnt_q;
  assign swap_cnt     = swap_q;
endmodule

// File: tb/tb_sprite_bank_mem.sv
// Scoreboard bench for sprite_bank_mem: a bank/state model predicts every read
// and the status outputs; results are compared one cycle after the address.
module tb_sprite_bank_mem;
  localparam int AW = 12, DW = 12, CW = 8, DEPTH = 4096;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic          rst_n;
  logic [AW-1:0] pixel_addr;
  logic [DW-1:0] rgb_pixel;
  logic          vsync_in;
  logic          front_bank, swap_pending;
  logic [AW:0]   wr_count;
  logic [CW-1:0] swap_cnt;

  sprite_bank_mem_if #(.ADDR_W(AW), .DATA_W(DW)) wr_if ();

  sprite_bank_mem #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .pixel_addr  (pixel_addr),
    .rgb_pixel   (rgb_pixel),
    .vsync_in    (vsync_in),
    .wr          (wr_if),
    .front_bank  (front_bank),
    .swap_pending(swap_pending),
    .wr_count    (wr_count),
    .swap_cnt    (swap_cnt)
  );

  typedef struct { bit v; logic [DW-1:0] d; } exp_t;
  exp_t sb_q[$];

  logic [DW-1:0] mdl   [2][DEPTH];
  bit            known [2][DEPTH];
  bit m_front, m_pend, m_load, m_vsd;
  int m_cnt, m_swap;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_front"}, 32'(front_bank),      32'(m_front));
    chk({tag, "_pend"},  32'(swap_pending),    32'(m_pend));
    chk({tag, "_cnt"},   32'(wr_count),        32'(m_cnt));
    chk({tag, "_swap"},  32'(swap_cnt),        32'(m_swap));
    chk({tag, "_rdy"},   32'(wr_if.wr_ready),  32'(m_load));
  endtask

  task automatic model_reset();
    m_front = 0; m_pend = 0; m_load = 1; m_vsd = 0; m_cnt = 0; m_swap = 0;
    sb_q.delete();
  endtask

  // One clock: predict from the driven inputs, clock, then score the read.
  task automatic tick();
    exp_t e;
    bit hs, rise;
    e.v = known[m_front][pixel_addr];
    e.d = mdl[m_front][pixel_addr];
    sb_q.push_back(e);
    hs   = wr_if.wr_valid && m_load;
    rise = vsync_in && !m_vsd;
    if (hs) begin
      mdl[!m_front][wr_if.wr_addr]   = wr_if.wr_data;
      known[!m_front][wr_if.wr_addr] = 1'b1;
      if (m_cnt < DEPTH) m_cnt++;
      if (wr_if.wr_last) begin m_load = 0; m_pend = 1; end
    end else if (!m_load && rise) begin
      m_front = !m_front; m_swap = (m_swap + 1) % 256;
      m_cnt = 0; m_pend = 0; m_load = 1;
    end
    m_vsd = vsync_in;
    @(posedge pclk); #1;
    e = sb_q.pop_front();
    if (e.v) chk("rd", 32'(rgb_pixel), 32'(e.d));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rgb"},   32'(rgb_pixel),    32'h0);
    chk({tag, "_front"}, 32'(front_bank),   32'h0);
    chk({tag, "_pend"},  32'(swap_pending), 32'h0);
    chk({tag, "_cnt"},   32'(wr_count),     32'h0);
    chk({tag, "_swap"},  32'(swap_cnt),     32'h0);
    chk({tag, "_rdy"},   32'(wr_if.wr_ready), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; pixel_addr = '0; vsync_in = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0; wr_if.wr_last = 1'b0;
    model_reset();
    #12;
    chk_reset_vals("rst");
    @(posedge pclk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      pixel_addr = AW'(i);
      tick();
      chk_state("idle");
    end

    // Fill the back bank with data = address.
    wr_if.wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_if.wr_addr = AW'(i);
      wr_if.wr_data = DW'(i);
      wr_if.wr_last = (i == DEPTH - 1);
      pixel_addr    = AW'($urandom);
      tick();
    end
    wr_if.wr_last = 1'b0;
    chk("load1_cnt",  32'(wr_count),       32'd4096);
    chk("load1_pend", 32'(swap_pending),   32'd1);
    chk("load1_rdy",  32'(wr_if.wr_ready), 32'd0);
    chk_state("load1");

    // Offered writes while waiting for vsync must be dropped.
    wr_if.wr_addr = 12'h010; wr_if.wr_data = 12'hABC;
    repeat (3) tick();
    chk("blk_rdy", 32'(wr_if.wr_ready), 32'd0);
    vsync_in = 1'b1;
    tick();
    wr_if.wr_valid = 1'b0;
    chk("swap1_front", 32'(front_bank), 32'd1);
    chk("swap1_cnt",   32'(swap_cnt),   32'd1);
    chk_state("swap1");
    pixel_addr = 12'h123; tick();
    chk("rd123", 32'(rgb_pixel), 32'h123);
    pixel_addr = 12'h010; tick();
    chk("rd010", 32'(rgb_pixel), 32'h010);
    vsync_in = 1'b0; tick();

    // Overfill bank 0 (count saturates); the final wr_last lands on a vsync rise.
    wr_if.wr_valid = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      wr_if.wr_addr = AW'(i % DEPTH);
      wr_if.wr_data = ~DW'(i % DEPTH);
      wr_if.wr_last = (i == DEPTH + 3);
      vsync_in      = (i == DEPTH + 3);
      pixel_addr    = AW'($urandom);
      tick();
    end
    wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
    chk("sat_cnt",    32'(wr_count),     32'd4096);
    chk("simul_pend", 32'(swap_pending), 32'd1);
    chk("simul_front",32'(front_bank),   32'd1);
    chk("simul_swap", 32'(swap_cnt),     32'd1);
    chk_state("simul");

    // Continuous read of one address across the swap.
    vsync_in = 1'b0; pixel_addr = 12'h040;
    tick(); tick();
    vsync_in = 1'b1;
    tick();
    chk("rd_old", 32'(rgb_pixel), 32'h040);
    tick();
    chk("rd_new",     32'(rgb_pixel), 32'hFBF);
    chk("swap2_cnt",  32'(swap_cnt),  32'd2);
    chk("swap2_front",32'(front_bank),32'd0);
    chk_state("swap2");
    vsync_in = 1'b0; tick();

    // Partial load, then an asynchronous reset between clock edges.
    wr_if.wr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_if.wr_addr = AW'(i);
      wr_if.wr_data = 12'h555;
      tick();
    end
    wr_if.wr_valid = 1'b0;
    chk("mid_cnt", 32'(wr_count),  32'd100);
    chk("mid_rgb", 32'(rgb_pixel), 32'hFBF);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    model_reset();
    @(posedge pclk); #1;
    rst_n = 1'b1;
    chk("post_rdy", 32'(wr_if.wr_ready), 32'd1);
    chk("post_cnt", 32'(wr_count),       32'd0);
    pixel_addr = 12'h123; tick();
    chk("persist", 32'(rgb_pixel), 32'hEDC);
    chk_state("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_bank_mem.md
Name: sprite_bank_mem

Overview:
- Double-buffered sprite pixel memory. It is the responder to the sprite drawer's pixel_addr/rgb_pixel read interface.
- The drawer reads 64x64 12-bit pixels from the front bank with fixed 1-cycle latency.
- A loader (UART/ROM copier) fills the back bank through a valid/ready write port.
- Banks swap only on a vsync rising edge, so a sprite never tears mid-frame.

Parameters:
- ADDR_W, 12, pixel address width; depth per bank = 2**ADDR_W, address = {y[5:0], x[5:0]}.
- DATA_W, 12, pixel width (RGB 4:4:4).
- CNT_W, 8, width of the swap counter.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pixel_addr  in  ADDR_W  read address from drawer.
- rgb_pixel  out  DATA_W  registered read data from front bank.
- vsync_in  in  1  vertical sync from the timing chain.
- wr_valid  in  1  loader has a pixel.
- wr_ready  out  1  block accepts a pixel this cycle.
- wr_addr  in  ADDR_W  back-bank write address.
- wr_data  in  DATA_W  back-bank write data.
- wr_last  in  1  qualifies final pixel of an image.
- front_bank  out  1  bank currently read (0/1).
- swap_pending  out  1  complete image waiting for vsync.
- wr_count  out  ADDR_W+1  pixels accepted since last swap.
- swap_cnt  out  CNT_W  number of swaps since reset, wraps.

Behaviour:
- Reset (async assert, sync release) values:
  - rgb_pixel=0, front_bank=0, swap_pending=0, wr_count=0, swap_cnt=0.
  - state=LOAD, vsync_d=0.
  - Memory contents are not reset.
- Read path:
  - rgb_pixel(t+1) = front bank[pixel_addr(t)], using front_bank as sampled at t.
  - Reads never stall.
  - Reads are independent of writes: writes target only the back bank (~front_bank).
- Edge detect: vsync_d registers vsync_in; vs_rise = vsync_in & ~vsync_d.
- State LOAD:
  - wr_ready=1.
  - On a handshake (wr_valid & wr_ready): back[wr_addr] <= wr_data; wr_count increments, saturating at 2**ADDR_W.
  - Duplicate addresses are allowed; the last write wins, and each handshake still counts.
  - If the handshake carries wr_last: go to WAIT_SWAP and set swap_pending=1 next cycle.
  - vs_rise in LOAD has no effect.
- State WAIT_SWAP:
  - wr_ready=0; wr_valid is ignored and no writes occur.
  - On vs_rise: toggle front_bank, swap_cnt+1 (wraps), clear wr_count and swap_pending, return to LOAD.
  - The new bank is visible to the read whose address is presented the cycle after vs_rise.
- Simultaneous events: a wr_last handshake in the same cycle as vs_rise does not swap. That edge is consumed in LOAD, and the swap occurs at the next vs_rise.
- Load from an empty state:
  - wr_last with wr_count=0 (single-pixel image) is legal.
  - Image size is not checked; unwritten back-bank locations keep stale data.
- vsync_in held high across reset release: vsync_d resets to 0, so a rise is seen on the first clock if vsync_in=1. This is harmless in LOAD.
- Reset mid-load: the partial image is discarded logically (wr_count=0, front_bank=0), but RAM data persists.
- Memory: two 2**ADDR_W x DATA_W arrays (or one 2*depth array indexed by bank), one registered read port, one write port. Must infer block RAM.
- wr_count saturates; swap_cnt wraps modulo 2**CNT_W.

Test Plan:
- Reset, then pixel_addr=0x000..0x003 -> rgb_pixel changes 1 cycle after each address; front_bank=0, wr_ready=1, swap_cnt=0.
- Load 4096 pixels, data=addr, wr_last on addr 0xFFF -> wr_count=4096, swap_pending=1, wr_ready=0. On next vsync rise, front_bank=1, swap_cnt=1, and a read of 0x123 returns 12'h123 one cycle later.
- During WAIT_SWAP, drive wr_valid=1, wr_addr=0x010, wr_data=0xABC -> no write. After the swap, a read of 0x010 still returns 0x010.
- wr_last handshake in the same cycle as vs_rise -> no swap at that edge; swap_pending=1. Swap occurs on the following rise, with swap_cnt incremented by exactly 1.
- Read 0x040 continuously across the swap cycle -> rgb_pixel shows old-bank data through the cycle after vs_rise, then new-bank data.
- Assert rst_n=0 asynchronously mid-load (wr_count=100) with no clock edge -> outputs go to reset values immediately. After release, wr_ready=1 and wr_count=0.
